// File: rtl/bless_nic.sv
// Local network interface for one bufferless deflection router: injection FIFO with
// head-of-line age stamping and starvation flag, plus a registered ejection port with destination check.
module bless_nic #(
  parameter logic [3:0] ADDR       = 4'b0000,
  parameter int          DEPTH      = 4,
  parameter int          STARVE_LIM = 16,
  parameter int          AGE_W      = 5,
  parameter int          DATA_W     = 32,
  localparam int         CTRL_W     = 5 + AGE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] node_ci,
  input  logic [DATA_W-1:0] node_di,
  input  logic              node_valid,
  output logic              node_ready,
  output logic [CTRL_W-1:0] rtr_ci,
  output logic [DATA_W-1:0] rtr_di,
  input  logic              rtr_ready,
  input  logic [CTRL_W-1:0] rtr_co,
  input  logic [DATA_W-1:0] rtr_do,
  output logic [CTRL_W-1:0] ej_co,
  output logic [DATA_W-1:0] ej_do,
  output logic              ej_valid,
  output logic              dest_err,
  output logic              starve,
  output logic [15:0]       inj_count
);

  // Control word layout, MSB first: {valid, dest[3:0], age[AGE_W-1:0]}
  localparam int VALID_BIT = CTRL_W - 1;
  localparam int DEST_HI   = CTRL_W - 2;
  localparam int DEST_LO   = AGE_W;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] STARVE_AT = AGE_W'(STARVE_LIM);
  localparam logic [AGE_W-1:0] AGE_MAX   = '1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [CTRL_W-1:0] ctrl_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [AGE_W-1:0] wait_reg;
  logic [15:0]      inj_count_reg;
  logic             live_reg;
  logic [CTRL_W-1:0] ej_co_reg;
  logic [DATA_W-1:0] ej_do_reg;
  logic              ej_valid_reg, dest_err_reg;

  logic empty, push, pop;

  assign empty      = (count_reg == '0);
  // live_reg keeps node_ready low until the first clock after reset release.
  assign node_ready = live_reg && (count_reg < FULL_CNT);
  assign push       = node_valid && node_ready;
  assign pop        = !empty && rtr_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= node_di;
      ctrl_mem[wr_ptr_reg] <= node_ci;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wait_reg      <= '0;
      inj_count_reg <= '0;
      live_reg      <= 1'b0;
    end else begin
      live_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
        inj_count_reg <= inj_count_reg + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (empty || pop)          wait_reg <= '0;
      else if (wait_reg != AGE_MAX) wait_reg <= wait_reg + AGE_W'(1);
    end
  end

  // Head flit is offered with its current wait as age; valid forced high.
  always_comb begin
    rtr_ci = '0;
    rtr_di = '0;
    if (!empty) begin
      rtr_ci              = ctrl_mem[rd_ptr_reg];
      rtr_ci[VALID_BIT]   = 1'b1;
      rtr_ci[AGE_W-1:0]   = wait_reg;
      rtr_di              = data_mem[rd_ptr_reg];
    end
  end

  assign starve    = !empty && (wait_reg >= STARVE_AT);
  assign inj_count = inj_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ej_co_reg    <= '0;
      ej_do_reg    <= '0;
      ej_valid_reg <= 1'b0;
      dest_err_reg <= 1'b0;
    end else begin
      ej_co_reg    <= rtr_co;
      ej_do_reg    <= rtr_do;
      ej_valid_reg <= rtr_co[VALID_BIT];
      dest_err_reg <= rtr_co[VALID_BIT] && (rtr_co[DEST_HI:DEST_LO] != ADDR);
    end
  end

  assign ej_co    = ej_co_reg;
  assign ej_do    = ej_do_reg;
  assign ej_valid = ej_valid_reg;
  assign dest_err = dest_err_reg;

endmodule
